mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one memory/resource port among 4 requesters
//  (e.g. fetch, load/store, DMA, debug). Drives the 2-bit select of the
//  4:1 port datapath mux (mux4x1) and a one-hot grant. Holds ownership
//  across multi-beat bursts, with a fairness cap on burst length.
// PARAMETERS
//  MAX_BURST  8  max beats per grant before forced release (>=1)
// PORTS
//  clk         in   1  single clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  req         in   4  req[i]=1: requester i wants the port; held for the whole burst
//  last        in   4  last[i]=1: current beat of requester i is its final beat
//  port_ready  in   1  shared port accepts a beat this cycle
//  gnt         out  4  one-hot owner, registered; 0 when idle
//  sel         out  2  owner index to the datapath mux select
//  port_valid  out  1  gnt owner is presenting a beat (busy & req[owner])
//  beat_ack    out  4  per-requester beat accepted (gnt & {4{port_valid & port_ready}})
//  busy        out  1  1 while in BUSY
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE, gnt=0, sel=0, busy=0,
//    beat count=0, last_owner=3 (requester 0 highest priority after reset).
//    Reset mid-burst aborts the burst; no beat is acked after reset edge.
//  - FSM states: IDLE, BUSY.
//  - IDLE: if |req, winner = first set bit scanning (last_owner+1) mod 4
//    upward with wrap. Next edge: state=BUSY, gnt=onehot(winner),
//    sel=winner, count=0. Req->gnt latency: 1 cycle. If req=0, stay IDLE.
//  - sel holds its last value in IDLE (mux stays stable); gnt=0 in IDLE.
//  - BUSY beat = req[owner] & port_ready; on each beat count+=1.
//    port_ready=0: no beat, count unchanged, grant held indefinitely.
//  - Release (next edge -> IDLE, gnt=0, last_owner=owner) when any of:
//    a) beat with last[owner]=1; b) beat that makes count==MAX_BURST;
//    c) req[owner]=0 (abandon; no beat). a and b together = one release.
//  - After every release exactly one IDLE cycle precedes the next grant
//    (no back-to-back grants); re-arbitration uses updated last_owner.
//  - A released requester still requesting competes normally; if alone,
//    it is re-granted after the single IDLE cycle.
//  - last[i] for non-owners and req changes of non-owners are ignored
//    during BUSY. gnt is never more than one-hot.
//  - count width = $clog2(MAX_BURST+1); never exceeds MAX_BURST.
//  - port_valid, beat_ack combinational from registered state and inputs.
// TESTING
//  1) Reset, req=4'b1111, last=4'b1111, port_ready=1 -> gnt 0001,0000,
//     0010,0000,0100,0000,1000,0000,0001 on successive cycles; sel follows.
//  2) req=4'b0100 only, 3-beat bursts -> gnt=0100 for 3 beats, 1 IDLE
//     cycle, re-grant 0100; sel stays 2'b10 throughout.
//  3) MAX_BURST=8, req=4'b0011, last=0, port_ready=1 -> req0 acked 8 beats,
//     forced release, IDLE 1 cycle, gnt=0010.
//  4) Owner 1 granted, port_ready=0 for 5 cycles -> no beat_ack, count
//     frozen, gnt stays 0010; beats resume when port_ready=1.
//  5) Owner 3 drops req mid-burst after 2 beats -> next edge IDLE, gnt=0;
//     pending req0 granted the cycle after (wrap from 3 to 0).
//  6) rst=1 during beat 4 of owner 2 -> next edge gnt=0, sel=0, busy=0;
//     with req=4'b0110 after rst release, gnt=0010 first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among four requesters.
// Owns the port for a whole burst, releasing on the owner's last beat, on
// hitting the burst-length cap, or when the owner drops its request. Every
// release is followed by exactly one idle cycle before the next grant.
module mem_port_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic       port_ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       port_valid,
  output logic [3:0] beat_ack,
  output logic       busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       last_owner;
  logic [CNT_W-1:0] count;
  logic [1:0]       winner;
  logic             any_req;
  logic             beat;
  logic             cap_hit;
  logic             release_burst;

  // Round-robin pick: first requester after the previous owner, with wrap.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    winner = last_owner;
    idx    = last_owner;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_owner + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req    = |req;
  assign busy       = (state == BUSY);
  assign port_valid = busy & req[sel];
  assign beat       = port_valid & port_ready;
  assign beat_ack   = gnt & {4{beat}};
  // The beat taken while count is MAX_BURST-1 is the one that reaches the cap.
  assign cap_hit    = (count == CNT_W'(MAX_BURST - 1));
  // Abandon needs no beat; last-beat and cap together form a single release.
  assign release_burst = busy & (~req[sel] | (beat & (last[sel] | cap_hit)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: grant from IDLE on any request, return to IDLE on release.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)       state_nxt = BUSY;
      BUSY:    if (release_burst) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, mux select, beat count and round-robin pointer; sel is left alone
  // on release so the datapath mux stays stable through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 4'b0000;
      sel        <= 2'd0;
      count      <= '0;
      last_owner <= 2'd3;
    end else if (state == IDLE) begin
      if (any_req) begin
        gnt   <= 4'b0001 << winner;
        sel   <= winner;
        count <= '0;
      end
    end else if (release_burst) begin
      gnt        <= 4'b0000;
      count      <= '0;
      last_owner <= sel;
    end else if (beat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural arbiter model.
module tb_mem_port_arbiter;

  localparam int MAX_BURST = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic       port_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       port_valid;
  logic [3:0] beat_ack;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int acks0  = 0;

  // Behavioural model: who owns the port, how many beats taken, who went last.
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_last;
  int m_sel;

  mem_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .port_ready(port_ready),
    .gnt(gnt), .sel(sel), .port_valid(port_valid), .beat_ack(beat_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_cnt   = 0;
    m_last  = 3;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l,
                            input logic pr, input logic rs);
    if (rs) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        if (!m_busy && r[(m_last + k) % 4]) begin
          m_busy  = 1'b1;
          m_owner = (m_last + k) % 4;
          m_sel   = m_owner;
          m_cnt   = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (pr) begin
      m_cnt++;
      if (l[m_owner] || m_cnt == MAX_BURST) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  endtask

  // One clock: apply inputs, check combinational outputs, clock the DUT and
  // the model, then check registered outputs.
  task automatic cycle(input logic [3:0] r, input logic [3:0] l,
                       input logic pr, input logic rs);
    logic       exp_pv;
    logic [3:0] exp_ack;
    req = r; last = l; port_ready = pr; rst = rs;
    #1;
    exp_pv  = m_busy && r[m_owner];
    exp_ack = (exp_pv && pr) ? (4'b0001 << m_owner) : 4'b0000;
    check("port_valid", 32'(port_valid), 32'(exp_pv));
    check("beat_ack", 32'(beat_ack), 32'(exp_ack));
    if (beat_ack[0]) acks0++;
    @(posedge clk);
    model_step(r, l, pr, rs);
    #1;
    check("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  initial begin
    logic [3:0] exp1 [9];
    logic [3:0] exp2 [9];
    logic [3:0] l;
    exp1 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
             4'b1000, 4'b0000, 4'b0001};
    exp2 = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100,
             4'b0100, 4'b0000, 4'b0100};

    req = '0; last = '0; port_ready = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Round robin with single-beat bursts from every requester.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
      check("rr_gnt", 32'(gnt), 32'(exp1[i]));
    end

    // Lone requester 2 with three-beat bursts, re-granted after one idle cycle.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      l = (m_busy && m_cnt == 2) ? 4'b0100 : 4'b0000;
      cycle(4'b0100, l, 1'b1, 1'b0);
      check("solo_gnt", 32'(gnt), 32'(exp2[i]));
      check("solo_sel", 32'(sel), 32'd2);
    end

    // Burst cap: requester 0 never signals last, forced off after MAX_BURST beats.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    acks0 = 0;
    for (int i = 0; i < MAX_BURST + 1; i++) cycle(4'b0011, 4'b0000, 1'b1, 1'b0);
    check("cap_release_gnt", 32'(gnt), 32'd0);
    check("cap_acks", 32'(acks0), 32'(MAX_BURST));
    cycle(4'b0011, 4'b0000, 1'b1, 1'b0);
    check("cap_next_gnt", 32'(gnt), 32'b0010);

    // Stall: port_ready low holds the grant with no beats.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    repeat (2) cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
      check("stall_ack", 32'(beat_ack), 32'd0);
      check("stall_gnt", 32'(gnt), 32'b0010);
    end
    #1;
    port_ready = 1'b1;
    #1;
    check("resume_ack", 32'(beat_ack), 32'b0010);
    cycle(4'b0010, 4'b0010, 1'b1, 1'b0);
    check("resume_release", 32'(gnt), 32'd0);

    // Owner 3 abandons mid-burst; pending requester 0 wins after the wrap.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    check("own3_gnt", 32'(gnt), 32'b1000);
    repeat (2) cycle(4'b1001, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
    check("abandon_gnt", 32'(gnt), 32'd0);
    cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
    check("wrap_gnt", 32'(gnt), 32'b0001);

    // Reset during beat 4 of owner 2.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    repeat (3) cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pv", 32'(port_valid), 32'd0);
    cycle(4'b0110, 4'b0000, 1'b1, 1'b0);
    check("post_rst_gnt", 32'(gnt), 32'b0010);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rr;
      logic [3:0] ll;
      rr = 4'($urandom);
      ll = 4'($urandom) & 4'($urandom);
      cycle(rr, ll, ($urandom_range(3) != 0), ($urandom_range(59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
